ga23_sdr_mux: RTL and testbench

Tile-row fetch multiplexer between the GA23 background layers and the single SDRAM graphics-ROM port. It consumes the one-cycle `sdr_req` pulses and 22-bit row addresses each layer emits on a tile load. It arbitrates them round-robin onto one level-held SDRAM request and routes the returned 32-bit row back to the requesting layer as `sdr_data` / `sdr_rdy`. Requests superseded before they complete are dropped and counted.

---
 rtl/ga23_pkg.sv | 13 +
 rtl/ga23_rr_arbiter.sv | 32 +++
 rtl/ga23_sdr_mux.sv | 150 +++++++++++++++
 tb/tb_ga23_sdr_mux.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga23_pkg.sv
// Shared constants and types for the GA23 background-layer SDRAM fetch path.
package ga23_pkg;

   localparam int GA23_SDR_ADDR_W = 22;
   localparam int GA23_SDR_DATA_W = 32;
   localparam int GA23_NUM_LAYERS = 3;

   typedef enum logic [0:0] {
      SDR_IDLE,
      SDR_BUSY
   } sdr_state_t;

endpackage

// File: rtl/ga23_rr_arbiter.sv
// Combinational round-robin pick: searches from last+1 (wrapping) for the first
// pending request and reports it as a one-hot grant plus its index.
module ga23_rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   // Walk the candidates in rotated order and keep the first one that is pending.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(last) + i) % N);
         if (!any && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ga23_sdr_mux.sv
// Tile-row fetch multiplexer: funnels per-layer request pulses onto one level-held
// SDRAM request and steers the returned row back to the layer that asked for it.
module ga23_sdr_mux
   import ga23_pkg::*;
#(
   parameter int NUM_LAYERS = GA23_NUM_LAYERS,
   parameter int ADDR_W     = GA23_SDR_ADDR_W,
   parameter int DATA_W     = GA23_SDR_DATA_W,
   parameter int IW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_LAYERS-1:0]        layer_req,
   input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
   output logic [NUM_LAYERS*DATA_W-1:0] layer_data,
   output logic [NUM_LAYERS-1:0]        layer_rdy,
   output logic                         sdr_req,
   output logic [ADDR_W-1:0]            sdr_addr,
   input  logic                         sdr_ack,
   input  logic [DATA_W-1:0]            sdr_data,
   output logic [7:0]                   drop_count
);

   sdr_state_t            state, state_next;
   logic [NUM_LAYERS-1:0] pend;
   logic [NUM_LAYERS-1:0] stale;
   logic [ADDR_W-1:0]     pend_addr [NUM_LAYERS];
   logic [IW-1:0]         last;

   logic [NUM_LAYERS-1:0] arb_grant;
   logic [IW-1:0]         arb_idx;
   logic                  arb_any;

   logic                  do_grant;
   logic                  ack_done;
   logic [NUM_LAYERS-1:0] grant_vec;
   logic [NUM_LAYERS-1:0] inflight;
   logic                  overwrite;
   logic                  stale_drop;
   logic [1:0]            drop_inc;
   logic [8:0]            drop_sum;

   ga23_rr_arbiter #(.N(NUM_LAYERS), .IW(IW)) u_arb (
      .req   (pend),
      .last  (last),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign do_grant   = (state == SDR_IDLE) && arb_any;
   assign ack_done   = (state == SDR_BUSY) && sdr_ack;
   assign grant_vec  = do_grant ? arb_grant : '0;
   assign stale_drop = ack_done && stale[last];
   // A request replaced while it is being granted is not an overwrite: the granted
   // copy goes out and gets marked stale instead, so it is only counted once.
   assign overwrite  = |(layer_req & pend & ~grant_vec);
   assign drop_inc   = {1'b0, overwrite} + {1'b0, stale_drop};
   assign drop_sum   = {1'b0, drop_count} + {7'b0, drop_inc};

   // Mark which layer owns the SDRAM port this cycle (being granted now or already busy).
   always_comb begin
      inflight = grant_vec;
      if (state == SDR_BUSY) begin
         inflight[last] = 1'b1;
      end
   end

   // Next-state logic: leave IDLE on any pending request, leave BUSY on ack.
   always_comb begin
      state_next = state;
      case (state)
         SDR_IDLE: if (arb_any) state_next = SDR_BUSY;
         SDR_BUSY: if (sdr_ack) state_next = SDR_IDLE;
         default:  state_next = SDR_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SDR_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Per-layer pending/stale bookkeeping; a new request always wins over a grant clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend  <= '0;
         stale <= '0;
         for (int g = 0; g < NUM_LAYERS; g++) begin
            pend_addr[g] <= '0;
         end
      end else begin
         for (int g = 0; g < NUM_LAYERS; g++) begin
            if (grant_vec[g]) begin
               pend[g]  <= 1'b0;
               stale[g] <= 1'b0;
            end
            if (ack_done && (last == IW'(g))) begin
               stale[g] <= 1'b0;
            end
            if (layer_req[g]) begin
               pend[g]      <= 1'b1;
               pend_addr[g] <= layer_addr[g*ADDR_W +: ADDR_W];
               if (inflight[g]) begin
                  stale[g] <= 1'b1;
               end
            end
         end
      end
   end

   // SDRAM handshake and return-data steering; last doubles as the in-flight layer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sdr_req    <= 1'b0;
         sdr_addr   <= '0;
         last       <= IW'(NUM_LAYERS - 1);
         layer_data <= '0;
         layer_rdy  <= '0;
      end else begin
         layer_rdy <= '0;
         if (do_grant) begin
            sdr_req  <= 1'b1;
            sdr_addr <= pend_addr[arb_idx];
            last     <= arb_idx;
         end
         if (ack_done) begin
            sdr_req <= 1'b0;
            if (!stale[last]) begin
               layer_data[last*DATA_W +: DATA_W] <= sdr_data;
               layer_rdy[last]                   <= 1'b1;
            end
         end
      end
   end

   // Saturating debug counter of discarded requests.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else begin
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule

// File: tb/tb_ga23_sdr_mux.sv
// Directed self-checking bench for ga23_sdr_mux.
module tb_ga23_sdr_mux;

   localparam int NL = 3;
   localparam int AW = 22;
   localparam int DW = 32;

   logic              clk;
   logic              reset;
   logic [NL-1:0]     layer_req;
   logic [NL*AW-1:0]  layer_addr;
   logic [NL*DW-1:0]  layer_data;
   logic [NL-1:0]     layer_rdy;
   logic              sdr_req;
   logic [AW-1:0]     sdr_addr;
   logic              sdr_ack;
   logic [DW-1:0]     sdr_data;
   logic [7:0]        drop_count;

   int checks   = 0;
   int failures = 0;

   ga23_sdr_mux dut (
      .clk        (clk),
      .reset      (reset),
      .layer_req  (layer_req),
      .layer_addr (layer_addr),
      .layer_data (layer_data),
      .layer_rdy  (layer_rdy),
      .sdr_req    (sdr_req),
      .sdr_addr   (sdr_addr),
      .sdr_ack    (sdr_ack),
      .sdr_data   (sdr_data),
      .drop_count (drop_count)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int g, input logic [AW-1:0] a);
      layer_addr[g*AW +: AW] = a;
   endtask

   task automatic do_reset();
      layer_req  = '0;
      layer_addr = '0;
      sdr_ack    = 1'b0;
      sdr_data   = '0;
      reset      = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (sdr_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_sdr_req got %0b want 0", sdr_req); end
      checks++;
      if (sdr_addr !== '0) begin failures++; $display("[TB] FAIL reset_sdr_addr got %h want 0", sdr_addr); end
      checks++;
      if (layer_rdy !== '0) begin failures++; $display("[TB] FAIL reset_layer_rdy got %b want 000", layer_rdy); end
      checks++;
      if (layer_data !== '0) begin failures++; $display("[TB] FAIL reset_layer_data got %h want 0", layer_data); end
      checks++;
      if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_drop_count got %0d want 0", drop_count); end
   endtask

   task automatic test_single();
      do_reset();
      layer_req = 3'b010;
      set_addr(1, 22'h12340);
      tick();
      layer_req = '0;
      checks++;
      if (sdr_req !== 1'b0) begin failures++; $display("[TB] FAIL single_req_early got %0b want 0", sdr_req); end
      tick();
      checks++;
      if (sdr_req !== 1'b1) begin failures++; $display("[TB] FAIL single_req got %0b want 1", sdr_req); end
      checks++;
      if (sdr_addr !== 22'h12340) begin failures++; $display("[TB] FAIL single_addr got %h want 12340", sdr_addr); end
      tick();
      tick();
      tick();
      sdr_ack  = 1'b1;
      sdr_data = 32'hDEADBEEF;
      tick();
      sdr_ack = 1'b0;
      checks++;
      if (layer_rdy !== 3'b010) begin failures++; $display("[TB] FAIL single_rdy got %b want 010", layer_rdy); end
      checks++;
      if (layer_data[1*DW +: DW] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_data got %h want deadbeef", layer_data[1*DW +: DW]); end
      checks++;
      if (sdr_req !== 1'b0) begin failures++; $display("[TB] FAIL single_req_drop got %0b want 0", sdr_req); end
      tick();
      checks++;
      if (layer_rdy !== 3'b000) begin failures++; $display("[TB] FAIL single_rdy_pulse got %b want 000", layer_rdy); end
      checks++;
      if (layer_data[1*DW +: DW] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_data_hold got %h want deadbeef", layer_data[1*DW +: DW]); end
   endtask

   task automatic test_contention();
      logic [AW-1:0] exp_addr [NL];
      logic [DW-1:0] exp_data [NL];
      logic [NL-1:0] exp_rdy;
      int n;
      exp_addr[0] = 22'h000A0; exp_addr[1] = 22'h000B0; exp_addr[2] = 22'h000C0;
      exp_data[0] = 32'h00001000; exp_data[1] = 32'h00001001; exp_data[2] = 32'h00001002;
      do_reset();
      layer_req = 3'b111;
      for (int g = 0; g < NL; g++) set_addr(g, exp_addr[g]);
      tick();
      layer_req = '0;
      for (int k = 0; k < NL; k++) begin
         n = 0;
         while (sdr_req !== 1'b1 && n < 10) begin tick(); n++; end
         checks++;
         if (sdr_req !== 1'b1) begin failures++; $display("[TB] FAIL contention_grant%0d got timeout want sdr_req", k); end
         checks++;
         if (sdr_addr !== exp_addr[k]) begin failures++; $display("[TB] FAIL contention_addr%0d got %h want %h", k, sdr_addr, exp_addr[k]); end
         sdr_ack  = 1'b1;
         sdr_data = exp_data[k];
         tick();
         sdr_ack = 1'b0;
         exp_rdy = '0;
         exp_rdy[k] = 1'b1;
         checks++;
         if (layer_rdy !== exp_rdy) begin failures++; $display("[TB] FAIL contention_rdy%0d got %b want %b", k, layer_rdy, exp_rdy); end
         checks++;
         if (layer_data[k*DW +: DW] !== exp_data[k]) begin failures++; $display("[TB] FAIL contention_data%0d got %h want %h", k, layer_data[k*DW +: DW], exp_data[k]); end
      end
      checks++;
      if (layer_data !== {exp_data[2], exp_data[1], exp_data[0]}) begin failures++; $display("[TB] FAIL contention_all_data got %h", layer_data); end
      checks++;
      if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL contention_drops got %0d want 0", drop_count); end
   endtask

   task automatic test_overwrite();
      int n;
      do_reset();
      layer_req = 3'b100;
      set_addr(2, 22'h002C0);
      tick();
      layer_req = '0;
      tick();
      checks++;
      if (sdr_addr !== 22'h002C0 || sdr_req !== 1'b1) begin failures++; $display("[TB] FAIL overwrite_busy2 got req=%0b addr=%h want req=1 addr=2c0", sdr_req, sdr_addr); end
      layer_req = 3'b001;
      set_addr(0, 22'h00100);
      tick();
      layer_req = '0;
      tick();
      layer_req = 3'b001;
      set_addr(0, 22'h00200);
      tick();
      layer_req = '0;
      checks++;
      if (drop_count !== 8'd1) begin failures++; $display("[TB] FAIL overwrite_drops got %0d want 1", drop_count); end
      sdr_ack  = 1'b1;
      sdr_data = 32'h22222222;
      tick();
      sdr_ack = 1'b0;
      checks++;
      if (layer_rdy !== 3'b100) begin failures++; $display("[TB] FAIL overwrite_rdy2 got %b want 100", layer_rdy); end
      n = 0;
      while (sdr_req !== 1'b1 && n < 10) begin tick(); n++; end
      checks++;
      if (sdr_addr !== 22'h00200 || sdr_req !== 1'b1) begin failures++; $display("[TB] FAIL overwrite_issue got req=%0b addr=%h want req=1 addr=200", sdr_req, sdr_addr); end
      sdr_ack  = 1'b1;
      sdr_data = 32'h00000200;
      tick();
      sdr_ack = 1'b0;
      checks++;
      if (layer_rdy !== 3'b001 || layer_data[0 +: DW] !== 32'h00000200) begin failures++; $display("[TB] FAIL overwrite_rdy0 got rdy=%b data=%h want rdy=001 data=200", layer_rdy, layer_data[0 +: DW]); end
      tick();
      tick();
      tick();
      checks++;
      if (sdr_req !== 1'b0 || drop_count !== 8'd1) begin failures++; $display("[TB] FAIL overwrite_no_reissue got req=%0b drops=%0d want req=0 drops=1", sdr_req, drop_count); end
   endtask

   task automatic test_stale();
      int n;
      do_reset();
      layer_req = 3'b010;
      set_addr(1, 22'h00111);
      tick();
      layer_req = '0;
      tick();
      checks++;
      if (sdr_addr !== 22'h00111 || sdr_req !== 1'b1) begin failures++; $display("[TB] FAIL stale_first_issue got req=%0b addr=%h want req=1 addr=111", sdr_req, sdr_addr); end
      layer_req = 3'b010;
      set_addr(1, 22'h00300);
      tick();
      layer_req = '0;
      checks++;
      if (drop_count !== 8'd0) begin failures++; $display("[TB] FAIL stale_pre_drops got %0d want 0", drop_count); end
      sdr_ack  = 1'b1;
      sdr_data = 32'h00000BAD;
      tick();
      sdr_ack = 1'b0;
      checks++;
      if (layer_rdy !== 3'b000) begin failures++; $display("[TB] FAIL stale_no_rdy got %b want 000", layer_rdy); end
      checks++;
      if (drop_count !== 8'd1) begin failures++; $display("[TB] FAIL stale_drops got %0d want 1", drop_count); end
      checks++;
      if (layer_data[1*DW +: DW] !== 32'h0) begin failures++; $display("[TB] FAIL stale_data_kept got %h want 0", layer_data[1*DW +: DW]); end
      n = 0;
      while (sdr_req !== 1'b1 && n < 10) begin tick(); n++; end
      checks++;
      if (sdr_addr !== 22'h00300 || sdr_req !== 1'b1) begin failures++; $display("[TB] FAIL stale_reissue got req=%0b addr=%h want req=1 addr=300", sdr_req, sdr_addr); end
      sdr_ack  = 1'b1;
      sdr_data = 32'h00003333;
      tick();
      sdr_ack = 1'b0;
      checks++;
      if (layer_rdy !== 3'b010 || layer_data[1*DW +: DW] !== 32'h00003333) begin failures++; $display("[TB] FAIL stale_second_rdy got rdy=%b data=%h want rdy=010 data=3333", layer_rdy, layer_data[1*DW +: DW]); end
   endtask

   task automatic test_reset_busy();
      do_reset();
      layer_req = 3'b001;
      set_addr(0, 22'h3ABCD);
      tick();
      layer_req = '0;
      tick();
      checks++;
      if (sdr_req !== 1'b1) begin failures++; $display("[TB] FAIL rstbusy_pre got %0b want 1", sdr_req); end
      reset = 1'b1;
      #1;
      checks++;
      if (sdr_req !== 1'b0 || sdr_addr !== '0) begin failures++; $display("[TB] FAIL rstbusy_async got req=%0b addr=%h want 0/0", sdr_req, sdr_addr); end
      tick();
      reset = 1'b0;
      tick();
      sdr_ack  = 1'b1;
      sdr_data = 32'hFFFFFFFF;
      tick();
      sdr_ack = 1'b0;
      checks++;
      if (sdr_req !== 1'b0 || layer_rdy !== 3'b000) begin failures++; $display("[TB] FAIL rstbusy_late_ack got req=%0b rdy=%b want 0/000", sdr_req, layer_rdy); end
      checks++;
      if (layer_data !== '0 || drop_count !== 8'd0 || sdr_addr !== '0) begin failures++; $display("[TB] FAIL rstbusy_outputs got data=%h drops=%0d addr=%h want zeros", layer_data, drop_count, sdr_addr); end
      tick();
      checks++;
      if (sdr_req !== 1'b0) begin failures++; $display("[TB] FAIL rstbusy_no_grant got %0b want 0", sdr_req); end
   endtask

   task automatic test_saturation();
      do_reset();
      layer_req = 3'b100;
      set_addr(2, 22'h00044);
      tick();
      layer_req = '0;
      tick();
      layer_req = 3'b001;
      for (int i = 0; i < 101; i++) begin
         set_addr(0, AW'(i));
         tick();
      end
      checks++;
      if (drop_count !== 8'd100) begin failures++; $display("[TB] FAIL sat_mid got %0d want 100", drop_count); end
      for (int i = 0; i < 200; i++) tick();
      checks++;
      if (drop_count !== 8'd255) begin failures++; $display("[TB] FAIL sat_full got %0d want 255", drop_count); end
      for (int i = 0; i < 5; i++) tick();
      layer_req = '0;
      tick();
      checks++;
      if (drop_count !== 8'd255) begin failures++; $display("[TB] FAIL sat_hold got %0d want 255", drop_count); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_single();
      test_contention();
      test_overwrite();
      test_stale();
      test_reset_busy();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
